// File: rtl/dmi_target.sv
// Core-side DMI responder: turns each DMI request into one register-bus access and
// returns exactly one response, with a timeout so a hung target cannot wedge the link.
module dmi_target #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [40:0] dmi_req_i,        // {addr[6:0], op[1:0], data[31:0]}
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output logic [33:0] dmi_resp_o,       // {data[31:0], resp[1:0]}
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [6:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic        reg_gnt_i,
  input  logic        reg_rvalid_i,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_err_i
);

  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = '1;
  // Firing when the count is about to reach TimeoutCycles puts RESP exactly
  // TimeoutCycles cycles after ISSUE was entered.
  localparam logic [CntW-1:0] TimeoutLast =
      CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  localparam logic [1:0] OpNop       = 2'd0;
  localparam logic [1:0] OpRead      = 2'd1;
  localparam logic [1:0] OpWrite     = 2'd2;
  localparam logic [1:0] RespSuccess = 2'd0;
  localparam logic [1:0] RespErr     = 2'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [6:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stale_q, stale_d;
  logic            live_q;
  logic            timeout;
  logic            req_ready, resp_valid, reg_req;
  logic [1:0]      req_op;

  assign req_op  = dmi_req_i[33:32];
  assign timeout = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    cnt_d      = cnt_q;
    stale_d    = stale_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    reg_req    = 1'b0;

    // A completion owed to an abandoned access is swallowed wherever it lands.
    if (stale_q && reg_rvalid_i) stale_d = 1'b0;
    if ((state_q inside {StIssue, StWait}) && (cnt_q != CntMax)) cnt_d = cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        req_ready = live_q;
        if (live_q && dmi_req_valid_i) begin
          addr_d  = dmi_req_i[40:34];
          we_d    = (req_op == OpWrite);
          wdata_d = dmi_req_i[31:0];
          rdata_d = '0;
          cnt_d   = '0;
          unique case (req_op)
            OpNop: begin
              state_d = StResp;
              rresp_d = RespSuccess;
            end
            OpRead, OpWrite: state_d = StIssue;
            default: begin
              state_d = StResp;
              rresp_d = RespErr;
            end
          endcase
        end
      end
      StIssue: begin
        reg_req = !stale_q;
        if (reg_req && reg_gnt_i) begin
          if (timeout) begin
            // Granted as we give up: the access is in flight, so its completion is stale.
            state_d = StResp;
            rdata_d = '0;
            rresp_d = RespErr;
            stale_d = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else if (timeout) begin
          state_d = StResp;
          rdata_d = '0;
          rresp_d = RespErr;
        end
      end
      StWait: begin
        if (reg_rvalid_i) begin
          state_d = StResp;
          rdata_d = we_q ? 32'h0 : reg_rdata_i;
          rresp_d = reg_err_i ? RespErr : RespSuccess;
        end else if (timeout) begin
          state_d = StResp;
          rdata_d = '0;
          rresp_d = RespErr;
          stale_d = 1'b1;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        if (dmi_resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      live_q  <= 1'b1;
    end
  end

  assign dmi_req_ready_o  = req_ready;
  assign dmi_resp_valid_o = resp_valid;
  assign dmi_resp_o       = {rdata_q, rresp_q};
  assign reg_req_o        = reg_req;
  assign reg_we_o         = we_q;
  assign reg_addr_o       = addr_q;
  assign reg_wdata_o      = wdata_q;

  rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
      reg_rvalid_i |-> (stale_q || state_q == StWait));

endmodule
